mem_access_unit: RTL

Parametrised memory-stage access unit for the RISC-V pipeline, successor to the single-cycle word-only load/store path. Sits between execute and writeback: accepts one operation per handshake, performs byte/half/word (and double for XLEN=64) loads and stores with byte enables, sign/zero extension and alignment checking, and talks to data memory over a variable-latency req/ack handshake, back-pressuring execute while a transfer is outstanding. Results leave on a registered one-cycle-valid output.

---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: sized, aligned accesses over a req/ack
// data-memory port, with a registered one-cycle result pulse.
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mem_op,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   reg_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   write_out,
    output logic              fault_misaligned,
    output logic              fault_illegal,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [1:0] MEM_SKIP_OP  = 2'd0;
    localparam logic [1:0] MEM_LOAD_OP  = 2'd1;
    localparam logic [1:0] MEM_STORE_OP = 2'd2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   write_out_q, write_out_d;
    logic              fmis_q, fmis_d;
    logic              fill_q, fill_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [OFS-1:0]    ofs_q, ofs_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;

    logic              is_load, is_store;
    logic [1:0]        size;
    logic [3:0]        nbytes;
    logic [OFS-1:0]    ofs;
    logic [OFS-1:0]    size_mask;
    logic              misaligned, illegal;
    logic [2*NB-1:0]   be_wide;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_val;

    always_comb begin
        is_load    = (mem_op == MEM_LOAD_OP);
        is_store   = (mem_op == MEM_STORE_OP);
        size       = funct3[1:0];
        nbytes     = 4'd1 << size;
        ofs        = alu_result[OFS-1:0];
        size_mask  = OFS'(nbytes - 4'd1);
        misaligned = |(ofs & size_mask);
        // RV32 has no doubleword access and no LWU
        illegal    = (is_store && (funct3[2] || (XLEN == 32 && size == 2'd3)))
                  || (is_load && (funct3 == 3'b111
                        || (XLEN == 32 && (size == 2'd3 || funct3 == 3'b110))));
        be_wide    = (((2*NB)'(1) << nbytes) - (2*NB)'(1)) << ofs;
        unique case (size)
            2'd0:    wdata = {NB{reg_data[7:0]}};
            2'd1:    wdata = {(NB/2){reg_data[15:0]}};
            2'd2:    wdata = {(NB/4){reg_data[31:0]}};
            default: wdata = reg_data;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {ofs_q, 3'b000};
        unique case (size_q)
            2'd0: load_val = uns_q ? XLEN'(shifted[7:0])
                                   : XLEN'($signed(shifted[7:0]));
            2'd1: load_val = uns_q ? XLEN'(shifted[15:0])
                                   : XLEN'($signed(shifted[15:0]));
            2'd2: load_val = uns_q ? XLEN'(shifted[31:0])
                                   : XLEN'($signed(shifted[31:0]));
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        write_out_d = write_out_q;
        fmis_d      = fmis_q;
        fill_d      = fill_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ofs_d       = ofs_q;
        size_d      = size_q;
        uns_d       = uns_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_valid_d = 1'b1;
                    write_out_d = '0;
                    fmis_d      = 1'b0;
                    fill_d      = 1'b0;
                    if (!(is_load || is_store)) begin
                        write_out_d = alu_result;
                    end else if (illegal) begin
                        fill_d = 1'b1;
                    end else if (misaligned) begin
                        fmis_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        write_out_d = write_out_q;
                        fmis_d      = fmis_q;
                        fill_d      = fill_q;
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {alu_result[XLEN-1:OFS], {OFS{1'b0}}};
                        mem_be_d    = be_wide[NB-1:0];
                        mem_wdata_d = wdata;
                        ofs_d       = ofs;
                        size_d      = size;
                        uns_d       = funct3[2];
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    write_out_d = mem_we_q ? '0 : load_val;
                    fmis_d      = 1'b0;
                    fill_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            write_out_q <= '0;
            fmis_q      <= 1'b0;
            fill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            ofs_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            write_out_q <= write_out_d;
            fmis_q      <= fmis_d;
            fill_q      <= fill_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ofs_q       <= ofs_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign out_valid        = out_valid_q;
    assign write_out        = write_out_q;
    assign fault_misaligned = fmis_q;
    assign fault_illegal    = fill_q;
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_be           = mem_be_q;
    assign mem_wdata        = mem_wdata_q;

endmodule
